// File: rtl/regfile_2r1w_pkg.sv
// rtl/regfile_2r1w_pkg.sv - shared constants and types for the 2-read/1-write register file
package regfile_2r1w_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef logic [AW_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// rtl/regfile_bypass_mux.sv - read-data select for one port: zero register, write bypass, then stored entry
module regfile_bypass_mux
  import regfile_2r1w_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [DW-1:0] i_entry_data,
  output logic [DW-1:0] o_rd_data
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (ZERO_REG != 0) && (i_rd_addr == AW'(REG_ZERO));
  assign w_hit     = i_we && (i_wr_addr == i_rd_addr);

  always_comb begin
    o_rd_data = i_entry_data;
    if (w_is_zero) begin
      o_rd_data = '0;
    end else if (w_hit) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register file with two registered read ports, one write port and write-through bypass
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WE,
  input  logic [AW-1:0] Awr,
  input  logic [DW-1:0] Din,
  input  logic          RdEn,
  input  logic [AW-1:0] Ard1,
  input  logic [AW-1:0] Ard2,
  output logic [DW-1:0] Dout1,
  output logic [DW-1:0] Dout2,
  output logic          Valid
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout1;
  logic [DW-1:0] r_dout2;
  logic          r_valid;
  logic [DW-1:0] w_rd1;
  logic [DW-1:0] w_rd2;
  logic          w_wr_en;

  // Writes to the hardwired zero entry are dropped so entry 0 never leaves 0.
  assign w_wr_en = WE && !((ZERO_REG != 0) && (Awr == AW'(REG_ZERO)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem <= '{default: '0};
    end else if (w_wr_en) begin
      r_mem[Awr] <= Din;
    end
  end

  regfile_bypass_mux #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_mux1 (
    .i_rd_addr    (Ard1),
    .i_we         (WE),
    .i_wr_addr    (Awr),
    .i_wr_data    (Din),
    .i_entry_data (r_mem[Ard1]),
    .o_rd_data    (w_rd1)
  );

  regfile_bypass_mux #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_mux2 (
    .i_rd_addr    (Ard2),
    .i_we         (WE),
    .i_wr_addr    (Awr),
    .i_wr_data    (Din),
    .i_entry_data (r_mem[Ard2]),
    .o_rd_data    (w_rd2)
  );

  // Read data holds when RdEn is low; only Valid drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout1 <= '0;
      r_dout2 <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= RdEn;
      if (RdEn) begin
        r_dout1 <= w_rd1;
        r_dout2 <= w_rd2;
      end
    end
  end

  assign Dout1 = r_dout1;
  assign Dout2 = r_dout2;
  assign Valid = r_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed vector bench for regfile_2r1w
module tb_regfile_2r1w;
  import regfile_2r1w_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WE;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        RdEn;
  logic [4:0]  Ard1;
  logic [4:0]  Ard2;
  logic [31:0] Dout1;
  logic [31:0] Dout2;
  logic        Valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  awr;
    logic [31:0] din;
    logic        rden;
    logic [4:0]  ard1;
    logic [4:0]  ard2;
    logic        exp_valid;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
  } vec_t;

  vec_t vecs[$];

  regfile_2r1w #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (WE),
    .Awr   (Awr),
    .Din   (Din),
    .RdEn  (RdEn),
    .Ard1  (Ard1),
    .Ard2  (Ard2),
    .Dout1 (Dout1),
    .Dout2 (Dout2),
    .Valid (Valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RST  = v.rst;
    WE   = v.we;
    Awr  = v.awr;
    Din  = v.din;
    RdEn = v.rden;
    Ard1 = v.ard1;
    Ard2 = v.ard2;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] e1, input logic [31:0] e2);
    chk({tag, " valid"}, {31'd0, Valid}, {31'd0, ev});
    chk({tag, " dout1"}, Dout1, e1);
    chk({tag, " dout2"}, Dout2, e2);
  endtask

  initial begin
    RST = 1'b0; WE = 1'b0; Awr = '0; Din = '0; RdEn = 1'b0; Ard1 = '0; Ard2 = '0;

    //                rst  we  awr    din            rden ard1  ard2   valid d1             d2
    vecs.push_back(vec_t'{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd31, 1'b1, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  1'b0, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd7,  1'b1, 32'hDEADBEEF, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 5'd3,  32'h12345678, 1'b1, 5'd3,  5'd3,  1'b1, 32'h12345678, 32'h12345678});
    vecs.push_back(vec_t'{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd3,  1'b1, 32'h0,        32'h12345678});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd5,  1'b1, 32'h0,        32'hDEADBEEF});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd3,  1'b1, 32'hDEADBEEF, 32'h12345678});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  5'd2,  1'b0, 32'hDEADBEEF, 32'h12345678});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd4,  5'd6,  1'b0, 32'hDEADBEEF, 32'h12345678});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd8,  5'd9,  1'b0, 32'hDEADBEEF, 32'h12345678});
    vecs.push_back(vec_t'{1'b1, 1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd5,  5'd3,  1'b0, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd5,  1'b1, 32'h0,        32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd3,  5'd31, 1'b1, 32'h0,        32'hCAFEF00D});
    vecs.push_back(vec_t'{1'b0, 1'b1, 5'd31, 32'h11112222, 1'b1, 5'd31, 5'd31, 1'b1, 32'h11112222, 32'h11112222});
    vecs.push_back(vec_t'{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd9,  1'b1, 32'h11112222, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check_out($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_d1, vecs[i].exp_d2);
    end

    // Reset landing between a write and its readback clears the array and drops the read.
    drive(vec_t'{1'b0, 1'b1, 5'd12, 32'h0BADF00D, 1'b1, 5'd31, 5'd12, 1'b1, 32'h0, 32'h0});
    check_out("seq write-bypass", 1'b1, 32'h11112222, 32'h0BADF00D);
    drive(vec_t'{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 1'b1, 32'h0, 32'h0});
    check_out("seq readback", 1'b1, 32'h0BADF00D, 32'h0BADF00D);
    drive(vec_t'{1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd31, 1'b0, 32'h0, 32'h0});
    check_out("seq reset", 1'b0, 32'h0, 32'h0);
    drive(vec_t'{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd31, 1'b1, 32'h0, 32'h0});
    check_out("seq post-reset", 1'b1, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
